// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and the
// accumulator width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Full-precision product width for a WIDTH_A x WIDTH_B multiply.
    function automatic int acc_width(input int width_a, input int width_b);
        return width_a + width_b;
    endfunction

endpackage

// File: rtl/twos_abs.sv
// Operand magnitude/sign extraction. In signed mode the most-negative value maps
// to its own unsigned bit pattern (e.g. 8'h80 -> 128).
module twos_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] value_i,
    input  logic         signed_mode_i,
    output logic [W-1:0] mag_o,
    output logic         neg_o
);

    assign neg_o = signed_mode_i & value_i[W-1];
    assign mag_o = neg_o ? (W'(0) - value_i) : value_i;

endmodule

// File: rtl/shift_add_multiplier_seq.sv
// Sequential radix-2 shift-add multiplier with signed/unsigned mode, early
// termination once the remaining multiplier bits are zero, and valid/ready on both sides.
module shift_add_multiplier_seq
    import mult_pkg::*;
#(
    parameter int WIDTH_A   = 8,
    parameter int WIDTH_B   = 8,
    parameter int WIDTH_OUT = WIDTH_A + WIDTH_B
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH_A-1:0]   multiplicand,
    input  logic [WIDTH_B-1:0]   multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] product
);

    localparam int ACC_W = acc_width(WIDTH_A, WIDTH_B);
    localparam int CNT_W = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     a_sh_q, a_sh_d;
    logic [WIDTH_B-1:0]   b_q, b_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 neg_q, neg_d;
    logic [WIDTH_OUT-1:0] product_q, product_d;

    logic [WIDTH_A-1:0]   mag_a;
    logic [WIDTH_B-1:0]   mag_b;
    logic                 neg_a, neg_b;

    twos_abs #(.W(WIDTH_A)) u_abs_a (
        .value_i       (multiplicand),
        .signed_mode_i (signed_mode),
        .mag_o         (mag_a),
        .neg_o         (neg_a)
    );

    twos_abs #(.W(WIDTH_B)) u_abs_b (
        .value_i       (multiplier),
        .signed_mode_i (signed_mode),
        .mag_o         (mag_b),
        .neg_o         (neg_b)
    );

    logic [ACC_W-1:0]   acc_step;
    logic [ACC_W-1:0]   acc_final;
    logic [WIDTH_B-1:0] b_shift;
    logic               last_step;

    // One shift-add step, plus the sign-corrected result used on the final step.
    always_comb begin
        acc_step  = b_q[0] ? (acc_q + a_sh_q) : acc_q;
        b_shift   = b_q >> 1;
        last_step = (b_shift == '0) || (count_q == CNT_W'(WIDTH_B - 1));
        acc_final = neg_q ? (ACC_W'(0) - acc_step) : acc_step;
    end

    always_comb begin
        // NOTE: every next-state signal is given its hold value first, so no path through the case infers a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        a_sh_d    = a_sh_q;
        b_d       = b_q;
        count_d   = count_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = ACC_W'(mag_a);
                    b_d     = mag_b;
                    neg_d   = neg_a ^ neg_b;
                    acc_d   = '0;
                    count_d = '0;
                    if (mag_a == '0 || mag_b == '0) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d   = acc_step;
                a_sh_d  = a_sh_q << 1;
                b_d     = b_shift;
                count_d = count_q + CNT_W'(1);
                if (last_step) begin
                    product_d = WIDTH_OUT'(acc_final);
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers are cleared too, so an aborted multiply leaves nothing behind.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_sh_q    <= '0;
            b_q       <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            acc_q     <= acc_d;
            a_sh_q    <= a_sh_d;
            b_q       <= b_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule
